// File: rtl/uart_fifo_ctrl.sv
// Parametrised synchronous FIFO between the UART shift engines and the host interface.
// Supports first-word-fall-through or registered read, occupancy flags and sticky error flags.
module uart_fifo_ctrl #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int FWFT   = 1,
    parameter int AF_LVL = 14,
    parameter int AE_LVL = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        din,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        dout,
    output logic                     dout_valid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow,
    input  logic                     clr_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              dout_valid_q, dout_valid_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    logic full_w;
    logic empty_w;
    logic wr_acc;
    logic rd_acc;

    // Handshake: a write is taken when wr_en is high and the registered full is low; a read
    // is taken when rd_en is high and the registered empty is low. Both are dropped during flush.
    assign full_w  = (count_q == CW'(DEPTH));
    assign empty_w = (count_q == '0);
    assign wr_acc  = wr_en && !full_w && !flush;
    assign rd_acc  = rd_en && !empty_w && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (rd_acc) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_comb begin
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        if (flush) begin
            dout_d       = '0;
            dout_valid_d = 1'b0;
        end else if (FWFT != 0) begin
            dout_valid_d = (count_d != '0);
            // The next head is the word being written this cycle when it lands where rd_ptr points.
            if (count_d != '0) begin
                if (wr_acc && (rd_ptr_d == wr_ptr_q)) begin
                    dout_d = din;
                end else begin
                    dout_d = mem_q[rd_ptr_d];
                end
            end
        end else begin
            dout_valid_d = rd_acc;
            if (rd_acc) begin
                dout_d = mem_q[rd_ptr_q];
            end
        end
    end

    // A set condition in the same cycle as clr_err leaves the flag set.
    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (clr_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (!flush && wr_en && full_w) begin
            overflow_d = 1'b1;
        end
        if (!flush && rd_en && empty_w) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

    assign dout         = dout_q;
    assign dout_valid   = dout_valid_q;
    assign count        = count_q;
    assign full         = full_w;
    assign empty        = empty_w;
    assign almost_full  = (count_q >= CW'(AF_LVL));
    assign almost_empty = (count_q <= CW'(AE_LVL));
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Bench for uart_fifo_ctrl: a 4-deep FWFT instance driven from a vector table and a
// standard-read instance sharing the same inputs, plus hand sequences for reset and read latency.
module tb_uart_fifo_ctrl;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    logic          flush;
    logic          wr_en;
    logic [DW-1:0] din;
    logic          rd_en;
    logic          clr_err;

    logic [DW-1:0] a_dout, b_dout;
    logic          a_dv, b_dv, a_full, b_full, a_empty, b_empty;
    logic          a_af, b_af, a_ae, b_ae, a_ov, b_ov, a_uf, b_uf;
    logic [CW-1:0] a_count, b_count;

    uart_fifo_ctrl #(.DATA_W(DW), .DEPTH(DEPTH), .FWFT(1), .AF_LVL(3), .AE_LVL(1)) u_fwft (
        .clk(clk), .reset_n(reset_n), .flush(flush), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .dout(a_dout), .dout_valid(a_dv), .full(a_full), .empty(a_empty),
        .almost_full(a_af), .almost_empty(a_ae), .count(a_count),
        .overflow(a_ov), .underflow(a_uf), .clr_err(clr_err)
    );

    uart_fifo_ctrl #(.DATA_W(DW), .DEPTH(DEPTH), .FWFT(0), .AF_LVL(3), .AE_LVL(1)) u_std (
        .clk(clk), .reset_n(reset_n), .flush(flush), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .dout(b_dout), .dout_valid(b_dv), .full(b_full), .empty(b_empty),
        .almost_full(b_af), .almost_empty(b_ae), .count(b_count),
        .overflow(b_ov), .underflow(b_uf), .clr_err(clr_err)
    );

    typedef struct {
        logic          fl;
        logic          we;
        logic [DW-1:0] d;
        logic          re;
        logic          clr;
        logic [CW-1:0] cnt;
        logic          dv;
        logic [DW-1:0] dout;
        logic          full;
        logic          empty;
        logic          af;
        logic          ae;
        logic          ov;
        logic          uf;
    } vec_t;

    vec_t vec_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input logic fl, input logic we, input logic [DW-1:0] d, input logic re,
                       input logic clr, input logic [CW-1:0] cnt, input logic dv,
                       input logic [DW-1:0] dout, input logic fu, input logic em,
                       input logic af, input logic ae, input logic ov, input logic uf);
        vec_t v;
        v.fl = fl; v.we = we; v.d = d; v.re = re; v.clr = clr;
        v.cnt = cnt; v.dv = dv; v.dout = dout; v.full = fu; v.empty = em;
        v.af = af; v.ae = ae; v.ov = ov; v.uf = uf;
        vec_q.push_back(v);
    endtask

    task automatic chk(input string name, input int step, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, step, act, exp);
        end
    endtask

    task automatic drive(input logic fl, input logic we, input logic [DW-1:0] d,
                         input logic re, input logic clr);
        flush = fl; wr_en = we; din = d; rd_en = re; clr_err = clr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a_reset(input int step);
        chk("a_reset_count", step, 32'(a_count), 0);
        chk("a_reset_dout", step, 32'(a_dout), 0);
        chk("a_reset_dv", step, 32'(a_dv), 0);
        chk("a_reset_empty", step, 32'(a_empty), 1);
        chk("a_reset_full", step, 32'(a_full), 0);
        chk("a_reset_af", step, 32'(a_af), 0);
        chk("a_reset_ae", step, 32'(a_ae), 1);
        chk("a_reset_ov", step, 32'(a_ov), 0);
        chk("a_reset_uf", step, 32'(a_uf), 0);
    endtask

    initial begin
        reset_n = 1'b0;
        drive(0, 0, 8'h00, 0, 0);
        tick();
        tick();
        chk_a_reset(-1);
        chk("b_reset_dout", -1, 32'(b_dout), 0);
        chk("b_reset_dv", -1, 32'(b_dv), 0);
        chk("b_reset_count", -1, 32'(b_count), 0);

        //  fl we din   re clr  cnt dv dout  full empty af ae ov uf
        add(0, 1, 8'hA1, 0, 0,  1, 1, 8'hA1, 0, 0, 0, 1, 0, 0);
        add(0, 1, 8'hB2, 0, 0,  2, 1, 8'hA1, 0, 0, 0, 0, 0, 0);
        add(0, 1, 8'hC3, 0, 0,  3, 1, 8'hA1, 0, 0, 1, 0, 0, 0);
        add(0, 1, 8'hD4, 0, 0,  4, 1, 8'hA1, 1, 0, 1, 0, 0, 0);
        add(0, 1, 8'hEE, 0, 0,  4, 1, 8'hA1, 1, 0, 1, 0, 1, 0);
        add(0, 0, 8'h00, 0, 0,  4, 1, 8'hA1, 1, 0, 1, 0, 1, 0);
        add(0, 0, 8'h00, 0, 1,  4, 1, 8'hA1, 1, 0, 1, 0, 0, 0);
        add(0, 0, 8'h00, 1, 0,  3, 1, 8'hB2, 0, 0, 1, 0, 0, 0);
        add(0, 0, 8'h00, 1, 0,  2, 1, 8'hC3, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            add(0, 1, 8'(8'h50 + i), 1, 0, 2, 1, (i == 0) ? 8'hD4 : 8'(8'h50 + i - 1),
                0, 0, 0, 0, 0, 0);
        end
        add(0, 0, 8'h00, 1, 0,  1, 1, 8'h57, 0, 0, 0, 1, 0, 0);
        add(0, 0, 8'h00, 1, 0,  0, 0, 8'h00, 0, 1, 0, 1, 0, 0);
        add(0, 0, 8'h00, 1, 0,  0, 0, 8'h00, 0, 1, 0, 1, 0, 1);
        add(0, 1, 8'h61, 1, 0,  1, 1, 8'h61, 0, 0, 0, 1, 0, 1);
        add(0, 1, 8'h62, 1, 0,  1, 1, 8'h62, 0, 0, 0, 1, 0, 1);
        add(0, 0, 8'h00, 0, 1,  1, 1, 8'h62, 0, 0, 0, 1, 0, 0);
        add(0, 1, 8'h63, 0, 0,  2, 1, 8'h62, 0, 0, 0, 0, 0, 0);
        add(0, 1, 8'h64, 0, 0,  3, 1, 8'h62, 0, 0, 1, 0, 0, 0);
        add(0, 1, 8'h65, 0, 0,  4, 1, 8'h62, 1, 0, 1, 0, 0, 0);
        add(1, 1, 8'h77, 0, 0,  0, 0, 8'h00, 0, 1, 0, 1, 0, 0);
        add(0, 1, 8'h88, 0, 0,  1, 1, 8'h88, 0, 0, 0, 1, 0, 0);
        add(0, 0, 8'h00, 1, 0,  0, 0, 8'h00, 0, 1, 0, 1, 0, 0);
        add(0, 0, 8'h00, 1, 0,  0, 0, 8'h00, 0, 1, 0, 1, 0, 1);

        reset_n = 1'b1;
        foreach (vec_q[i]) begin
            drive(vec_q[i].fl, vec_q[i].we, vec_q[i].d, vec_q[i].re, vec_q[i].clr);
            tick();
            chk("count", i, 32'(a_count), 32'(vec_q[i].cnt));
            chk("dout_valid", i, 32'(a_dv), 32'(vec_q[i].dv));
            if (vec_q[i].dv) begin
                chk("dout", i, 32'(a_dout), 32'(vec_q[i].dout));
            end
            chk("full", i, 32'(a_full), 32'(vec_q[i].full));
            chk("empty", i, 32'(a_empty), 32'(vec_q[i].empty));
            chk("almost_full", i, 32'(a_af), 32'(vec_q[i].af));
            chk("almost_empty", i, 32'(a_ae), 32'(vec_q[i].ae));
            chk("overflow", i, 32'(a_ov), 32'(vec_q[i].ov));
            chk("underflow", i, 32'(a_uf), 32'(vec_q[i].uf));
        end

        // Mid-stream reset: one word queued, underflow still set, write requested during reset.
        drive(0, 1, 8'h99, 0, 0);
        tick();
        chk("pre_reset_count", 100, 32'(a_count), 1);
        chk("pre_reset_uf", 100, 32'(a_uf), 1);
        reset_n = 1'b0;
        drive(0, 1, 8'hAB, 1, 0);
        tick();
        chk_a_reset(101);
        reset_n = 1'b1;
        drive(0, 0, 8'h00, 0, 0);
        tick();
        chk_a_reset(102);
        drive(0, 1, 8'h42, 0, 0);
        tick();
        chk("post_reset_count", 103, 32'(a_count), 1);
        chk("post_reset_dout", 103, 32'(a_dout), 32'h42);
        chk("post_reset_dv", 103, 32'(a_dv), 1);

        // Standard-read latency on the FWFT=0 instance.
        reset_n = 1'b0;
        drive(0, 0, 8'h00, 0, 0);
        tick();
        reset_n = 1'b1;
        drive(0, 1, 8'h11, 0, 0);
        tick();
        chk("std_wr1_dv", 200, 32'(b_dv), 0);
        chk("std_wr1_count", 200, 32'(b_count), 1);
        drive(0, 1, 8'h22, 0, 0);
        tick();
        chk("std_wr2_dv", 201, 32'(b_dv), 0);
        chk("std_wr2_count", 201, 32'(b_count), 2);
        drive(0, 0, 8'h00, 1, 0);
        tick();
        chk("std_rd1_dv", 202, 32'(b_dv), 1);
        chk("std_rd1_dout", 202, 32'(b_dout), 32'h11);
        chk("std_rd1_count", 202, 32'(b_count), 1);
        drive(0, 0, 8'h00, 0, 0);
        tick();
        chk("std_idle1_dv", 203, 32'(b_dv), 0);
        chk("std_idle1_dout", 203, 32'(b_dout), 32'h11);
        drive(0, 0, 8'h00, 1, 0);
        tick();
        chk("std_rd2_dv", 204, 32'(b_dv), 1);
        chk("std_rd2_dout", 204, 32'(b_dout), 32'h22);
        chk("std_rd2_empty", 204, 32'(b_empty), 1);
        drive(0, 0, 8'h00, 0, 0);
        tick();
        chk("std_idle2_dv", 205, 32'(b_dv), 0);
        chk("std_idle2_dout", 205, 32'(b_dout), 32'h22);
        chk("std_uf", 205, 32'(b_uf), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
